// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer and its branch LUT.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

    localparam int A_DEF          = 10;
    localparam int L_DEF          = 4;
    localparam int START_ADDR_DEF = 0;

endpackage

// File: rtl/branch_lut.sv
// Branch-target register file: 2**L entries of A bits, one write port, one read port.
// Latency: write lands on the next edge; read is combinational (same-cycle write reads old data).
// Backpressure: none; a write is accepted every cycle it is enabled.
module branch_lut #(
    parameter int A = fetch_pkg::A_DEF,
    parameter int L = fetch_pkg::L_DEF
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         wr_vld,
    input  logic [L-1:0] wr_idx,
    input  logic [A-1:0] wr_dat,
    input  logic [L-1:0] rd_idx,
    output logic [A-1:0] rd_dat
);

    logic [A-1:0] mem [2**L];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < 2**L; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_vld) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter controller: Start/Done handshake, sequential fetch, stall, LUT branches, halt.
// Latency: control inputs in cycle n set InstAddress in cycle n+1; Start gives RUN one edge later.
// Backpressure: Stall holds the PC for one cycle; Halt parks the PC and waits for a new Start.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int A          = A_DEF,
    parameter int L          = L_DEF,
    parameter int START_ADDR = START_ADDR_DEF,
    parameter int CW         = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          Halt,
    input  logic          Stall,
    input  logic          BranchTaken,
    input  logic          BranchAbs,
    input  logic [L-1:0]  BranchIdx,
    input  logic          LutWe,
    input  logic [L-1:0]  LutWaddr,
    input  logic [A-1:0]  LutWdata,
    output logic [A-1:0]  InstAddress,
    output logic          InstValid,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    localparam logic [A-1:0]  START_PC = A'(START_ADDR);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    fetch_state_t  state, state_nxt;
    logic [A-1:0]  pc, pc_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [A-1:0]  lut_dat;

    branch_lut #(
        .A (A),
        .L (L)
    ) u_branch_lut (
        .core_clk (Clk),
        .arst_n   (Reset_n),
        .wr_vld   (LutWe),
        .wr_idx   (LutWaddr),
        .wr_dat   (LutWdata),
        .rd_idx   (BranchIdx),
        .rd_dat   (lut_dat)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
            pc    <= START_PC;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                pc_nxt = START_PC;
                if (Start) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
                // Halt beats Stall beats branch; the halt address stays on the bus.
                if (Halt) begin
                    state_nxt = ST_DONE;
                end else if (!Stall) begin
                    if (BranchTaken) begin
                        pc_nxt = BranchAbs ? lut_dat : pc + lut_dat;
                    end else begin
                        pc_nxt = pc + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (Start) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = START_PC;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                pc_nxt    = START_PC;
            end
        endcase
    end

    assign InstAddress = pc;
    assign InstValid   = (state == ST_RUN);
    assign Busy        = (state == ST_RUN);
    assign Done        = (state == ST_DONE);
    assign CycleCount  = cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scenarios plus randomized traffic, all checked against an arithmetic reference model.
module tb_fetch_sequencer;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;
    localparam int AMOD   = 1024;
    localparam int CMAX   = 65535;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic        Halt;
    logic        Stall;
    logic        BranchTaken;
    logic        BranchAbs;
    logic [3:0]  BranchIdx;
    logic        LutWe;
    logic [3:0]  LutWaddr;
    logic [9:0]  LutWdata;
    logic [9:0]  InstAddress;
    logic        InstValid;
    logic        Busy;
    logic        Done;
    logic [15:0] CycleCount;

    int n_checks;
    int n_pass;

    int m_state;
    int m_pc;
    int m_cnt;
    int m_lut [16];

    fetch_sequencer #(
        .A          (10),
        .L          (4),
        .START_ADDR (0),
        .CW         (16)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .Halt        (Halt),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .BranchAbs   (BranchAbs),
        .BranchIdx   (BranchIdx),
        .LutWe       (LutWe),
        .LutWaddr    (LutWaddr),
        .LutWdata    (LutWdata),
        .InstAddress (InstAddress),
        .InstValid   (InstValid),
        .Busy        (Busy),
        .Done        (Done),
        .CycleCount  (CycleCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = 0;
        m_cnt   = 0;
        for (int i = 0; i < 16; i++) m_lut[i] = 0;
    endtask

    task automatic check_all();
        check("pc",    32'(InstAddress), 32'(m_pc));
        check("valid", 32'(InstValid),   32'(m_state == M_RUN));
        check("busy",  32'(Busy),        32'(m_state == M_RUN));
        check("done",  32'(Done),        32'(m_state == M_DONE));
        check("cnt",   32'(CycleCount),  32'(m_cnt));
    endtask

    task automatic clear_inputs();
        Start = 0; Halt = 0; Stall = 0; BranchTaken = 0; BranchAbs = 0;
        BranchIdx = 0; LutWe = 0; LutWaddr = 0; LutWdata = 0;
    endtask

    // One clock: predict from current inputs, let the edge happen, compare 1ns later.
    task automatic step();
        int n_state;
        int n_pc;
        int n_cnt;
        n_state = m_state;
        n_pc    = m_pc;
        n_cnt   = m_cnt;
        if (m_state == M_IDLE) begin
            n_pc = 0;
            if (Start) begin n_state = M_RUN; n_cnt = 0; end
        end else if (m_state == M_RUN) begin
            n_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            if (Halt)             n_state = M_DONE;
            else if (Stall)       n_pc = m_pc;
            else if (BranchTaken) n_pc = BranchAbs ? m_lut[BranchIdx]
                                                   : (m_pc + m_lut[BranchIdx]) % AMOD;
            else                  n_pc = (m_pc + 1) % AMOD;
        end else begin
            if (Start) begin n_state = M_RUN; n_pc = 0; n_cnt = 0; end
        end
        if (LutWe) m_lut[LutWaddr] = int'(LutWdata);
        @(posedge Clk);
        #1;
        m_state = n_state;
        m_pc    = n_pc;
        m_cnt   = n_cnt;
        check_all();
    endtask

    task automatic lut_write(input int idx, input int val);
        LutWe = 1; LutWaddr = 4'(idx); LutWdata = 10'(val);
        step();
        LutWe = 0;
    endtask

    task automatic branch(input int idx, input logic abs_sel);
        BranchTaken = 1; BranchAbs = abs_sel; BranchIdx = 4'(idx);
        step();
        BranchTaken = 0;
    endtask

    task automatic restart();
        Start = 1;
        step();
        Start = 0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clear_inputs();
        model_reset();
        Reset_n = 0;

        // Reset values
        #3;
        check("rst_pc",    32'(InstAddress), 32'd0);
        check("rst_valid", 32'(InstValid),   32'd0);
        check("rst_done",  32'(Done),        32'd0);
        check("rst_cnt",   32'(CycleCount),  32'd0);
        #10;
        Reset_n = 1;
        for (int i = 0; i < 3; i++) step();
        check("idle_pc", 32'(InstAddress), 32'd0);

        // Sequential run then halt at 5
        restart();
        check("start_pc", 32'(InstAddress), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check("seq_pc", 32'(InstAddress), 32'(i));
        end
        Halt = 1;
        step();
        Halt = 0;
        check("halt_done", 32'(Done),        32'd1);
        check("halt_pc",   32'(InstAddress), 32'd5);
        check("halt_cnt",  32'(CycleCount),  32'd6);
        step();
        check("hold_pc", 32'(InstAddress), 32'd5);
        restart();
        check("restart_pc",   32'(InstAddress), 32'd0);
        check("restart_done", 32'(Done),        32'd0);

        // Branches
        lut_write(2, 100);
        lut_write(3, 10'h3FC);
        for (int i = 0; i < 20 && m_pc != 7; i++) step();
        check("pre_br_pc", 32'(InstAddress), 32'd7);
        branch(2, 1'b1);
        check("abs_br", 32'(InstAddress), 32'd100);
        branch(3, 1'b0);
        check("rel_br", 32'(InstAddress), 32'd96);

        // Priority: halt over everything
        lut_write(4, 10);
        branch(4, 1'b1);
        check("pc10", 32'(InstAddress), 32'd10);
        Halt = 1; Stall = 1; BranchTaken = 1; BranchAbs = 1; BranchIdx = 2;
        step();
        clear_inputs();
        check("prio_done", 32'(Done),        32'd1);
        check("prio_pc",   32'(InstAddress), 32'd10);
        restart();
        lut_write(7, 20);
        branch(7, 1'b1);
        Stall = 1; BranchTaken = 1; BranchAbs = 1; BranchIdx = 2;
        step();
        check("stall_pc", 32'(InstAddress), 32'd20);
        Stall = 0;
        step();
        BranchTaken = 0;
        check("post_stall_br", 32'(InstAddress), 32'd100);

        // Wrap
        lut_write(5, 1022);
        branch(5, 1'b1);
        check("pc1022", 32'(InstAddress), 32'd1022);
        step();
        check("pc1023", 32'(InstAddress), 32'd1023);
        step();
        check("wrap0", 32'(InstAddress), 32'd0);

        // Same-cycle write/read returns the old entry
        LutWe = 1; LutWaddr = 1; LutWdata = 50;
        branch(1, 1'b1);
        LutWe = 0;
        check("collide_old", 32'(InstAddress), 32'd0);
        step();
        branch(1, 1'b1);
        check("collide_new", 32'(InstAddress), 32'd50);

        // Asynchronous reset between edges
        lut_write(6, 37);
        branch(6, 1'b1);
        check("pc37", 32'(InstAddress), 32'd37);
        #2;
        Reset_n = 0;
        #1;
        check("arst_pc",    32'(InstAddress), 32'd0);
        check("arst_valid", 32'(InstValid),   32'd0);
        check("arst_busy",  32'(Busy),        32'd0);
        check("arst_cnt",   32'(CycleCount),  32'd0);
        model_reset();
        #2;
        Reset_n = 1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            Start       = ($urandom_range(0, 11) == 0);
            Halt        = ($urandom_range(0, 23) == 0);
            Stall       = ($urandom_range(0, 3) == 0);
            BranchTaken = ($urandom_range(0, 3) == 0);
            BranchAbs   = 1'($urandom_range(0, 1));
            BranchIdx   = 4'($urandom_range(0, 15));
            LutWe       = ($urandom_range(0, 3) == 0);
            LutWaddr    = 4'($urandom_range(0, 15));
            LutWdata    = 10'($urandom_range(0, 1023));
            step();
        end
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
